// File: rtl/vcve2_mem_arbiter_pkg.sv
// vcve2_mem_arbiter_pkg: shared types for the instr/data memory arbiter.
package vcve2_mem_arbiter_pkg;
   typedef enum logic {ArbSrcInstr = 1'b0, ArbSrcData = 1'b1} arb_src_e;
   typedef enum logic [1:0] {ArbIdle, ArbLockI, ArbLockD} arb_state_e;
endpackage

// File: rtl/vcve2_arb_id_fifo.sv
// vcve2_arb_id_fifo: in-order FIFO of transaction source ids.
module vcve2_arb_id_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 1,
   parameter int unsigned CW    = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned PW = Depth > 1 ? $clog2(Depth) : 1;
   logic [Width-1:0] mem_q [Depth];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
   endfunction
   // a pop frees the slot a same-cycle push needs when full
   assign do_pop  = pop_i & !empty_o;
   assign do_push = push_i & (!full_o | do_pop);
   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = count_q == CW'(Depth);
   assign empty_o = count_q == '0;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= nxt(wptr_q);
         end
         if (do_pop) rptr_q <= nxt(rptr_q);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/vcve2_mem_arbiter.sv
// vcve2_mem_arbiter: merges instr fetch and LSU ports onto one memory bus,
// routing responses back in issue order.
module vcve2_mem_arbiter
   import vcve2_mem_arbiter_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned StarveLimit    = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        busy_o
);
   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   localparam int unsigned SW = $clog2(StarveLimit + 1);
   arb_state_e    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [CW-1:0] count;
   logic [0:0]    head;
   logic          full, empty, pop, sel_instr, gnt;
   // a locked owner keeps the bus until granted so the payload stays stable
   assign sel_instr = (state_q == ArbLockI) |
                      ((state_q == ArbIdle) & instr_req_i &
                       ((starve_q == SW'(StarveLimit)) | !data_req_i));
   assign pop       = mem_rvalid_i & !empty;
   assign mem_req_o = (sel_instr ? instr_req_i : data_req_i) & (!full | pop);
   assign gnt       = mem_req_o & mem_gnt_i;
   assign mem_we_o    = mem_req_o & !sel_instr & data_we_i;
   assign mem_be_o    = !mem_req_o ? '0 : sel_instr ? 4'hF : data_be_i;
   assign mem_addr_o  = !mem_req_o ? '0 : sel_instr ? instr_addr_i : data_addr_i;
   assign mem_wdata_o = (mem_req_o & !sel_instr) ? data_wdata_i : '0;
   assign instr_gnt_o = gnt & sel_instr;
   assign data_gnt_o  = gnt & !sel_instr;
   assign instr_rvalid_o = pop & (head == ArbSrcInstr);
   assign data_rvalid_o  = pop & (head == ArbSrcData);
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign instr_err_o    = mem_err_i;
   assign data_err_o     = mem_err_i;
   assign busy_o = instr_req_i | data_req_i | (count != '0);
   assign state_d  = (mem_req_o & !mem_gnt_i) ? (sel_instr ? ArbLockI : ArbLockD) : ArbIdle;
   assign starve_d = (!instr_req_i | instr_gnt_o) ? '0 :
                     (data_gnt_o & (starve_q != SW'(StarveLimit))) ? starve_q + SW'(1) : starve_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ArbIdle;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end
   vcve2_arb_id_fifo #(.Depth(MaxOutstanding), .Width(1), .CW(CW)) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (gnt),
      .data_i  (sel_instr ? ArbSrcInstr : ArbSrcData),
      .pop_i   (mem_rvalid_i),
      .head_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );
   a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, data_gnt_o,
                   data_rvalid_o, data_rdata_o, data_err_o, mem_req_o, mem_we_o, mem_be_o,
                   mem_addr_o, mem_wdata_o, busy_o}));
   a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (mem_req_o & !mem_gnt_i) |=>
      (mem_req_o & $stable({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o})));
   a_one_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) !(instr_gnt_o & data_gnt_o));
   a_no_stray: assert property (@(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> !empty);
   a_count: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CW'(MaxOutstanding));
endmodule

// File: tb/tb_vcve2_mem_arbiter.sv
// tb_vcve2_mem_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_vcve2_mem_arbiter;
   localparam int MaxOut = 2;
   localparam int Starve = 4;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        instr_req_i = 0, data_req_i = 0, data_we_i = 0;
   logic [31:0] instr_addr_i = 0, data_addr_i = 0, data_wdata_i = 0, mem_rdata_i = 0;
   logic [3:0]  data_be_i = 0;
   logic        mem_gnt_i = 0, mem_rvalid_i = 0, mem_err_i = 0;
   logic        instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
   logic        mem_req_o, mem_we_o, busy_o;
   logic [3:0]  mem_be_o;
   int          tests = 0, fails = 0;

   vcve2_mem_arbiter #(.MaxOutstanding(MaxOut), .StarveLimit(Starve)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [140:0] all_outs();
      return {instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, data_gnt_o, data_rvalid_o,
              data_rdata_o, data_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o};
   endfunction

   task automatic test_reset();
      #4;
      tests++; if (all_outs() !== '0) begin fails++; $display("FAIL reset.outs got=%h exp=0", all_outs()); end
      cyc();
      rst_ni = 1'b1;
      cyc();
   endtask

   task automatic test_instr_only();
      instr_req_i = 1; instr_addr_i = 32'h80; mem_gnt_i = 0; #4;
      tests++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h80, 32'h0}) begin
         fails++; $display("FAIL instr.payload got=%b/%b/%h/%h/%h exp=1/0/f/80/0", mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
      tests++; if (instr_gnt_o !== 1'b0) begin fails++; $display("FAIL instr.early_gnt got=%b exp=0", instr_gnt_o); end
      cyc();
      mem_gnt_i = 1; #4;
      tests++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin fails++; $display("FAIL instr.gnt got=%b exp=10", {instr_gnt_o, data_gnt_o}); end
      cyc();
      instr_req_i = 0; mem_gnt_i = 0; #4;
      tests++; if ({mem_req_o, busy_o} !== 2'b01) begin fails++; $display("FAIL instr.wait got=%b exp=01", {mem_req_o, busy_o}); end
      cyc();
      mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; #4;
      tests++; if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
         fails++; $display("FAIL instr.resp got=%b%b %h exp=10 deadbeef", instr_rvalid_o, data_rvalid_o, instr_rdata_o); end
      cyc();
      mem_rvalid_i = 0; mem_rdata_i = 0; #4;
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL instr.idle busy got=%b exp=0", busy_o); end
      cyc();
   endtask

   task automatic test_both();
      instr_req_i = 1; instr_addr_i = 32'h200;
      data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h100; data_wdata_i = 32'h12345678;
      mem_gnt_i = 1; #4;
      tests++; if ({instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {3'b011, 4'h3, 32'h100, 32'h12345678}) begin
         fails++; $display("FAIL both.data_first got=%b%b%b %h %h %h", instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
      cyc();
      data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0; #4;
      tests++; if ({instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o} !== {3'b100, 4'hF, 32'h200}) begin
         fails++; $display("FAIL both.instr_second got=%b%b%b %h %h", instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o); end
      cyc();
      instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hD; mem_err_i = 1; #4;
      tests++; if ({instr_rvalid_o, data_rvalid_o, data_err_o} !== 3'b011) begin
         fails++; $display("FAIL both.resp_d got=%b exp=011", {instr_rvalid_o, data_rvalid_o, data_err_o}); end
      cyc();
      mem_rdata_i = 32'h1; mem_err_i = 0; #4;
      tests++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
         fails++; $display("FAIL both.resp_i got=%b exp=10", {instr_rvalid_o, data_rvalid_o}); end
      cyc();
      mem_rvalid_i = 0; mem_rdata_i = 0;
      cyc();
   endtask

   task automatic test_lock();
      data_req_i = 1; data_addr_i = 32'h300; data_be_i = 4'hF; mem_gnt_i = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin instr_req_i = 1; instr_addr_i = 32'h400; end
         #4;
         tests++; if ({mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o} !== {1'b1, 32'h300, 2'b00}) begin
            fails++; $display("FAIL lock.hold[%0d] got=%b %h %b%b exp=1 300 00", i, mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o); end
         cyc();
      end
      mem_gnt_i = 1; #4;
      tests++; if ({mem_addr_o, instr_gnt_o, data_gnt_o} !== {32'h300, 2'b01}) begin
         fails++; $display("FAIL lock.release got=%h %b%b exp=300 01", mem_addr_o, instr_gnt_o, data_gnt_o); end
      cyc();
      data_req_i = 0; #4;
      tests++; if ({mem_addr_o, instr_gnt_o} !== {32'h400, 1'b1}) begin
         fails++; $display("FAIL lock.then_instr got=%h %b exp=400 1", mem_addr_o, instr_gnt_o); end
      cyc();
      instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #4;
      tests++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin fails++; $display("FAIL lock.resp_d got=%b exp=01", {instr_rvalid_o, data_rvalid_o}); end
      cyc(); #4;
      tests++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin fails++; $display("FAIL lock.resp_i got=%b exp=10", {instr_rvalid_o, data_rvalid_o}); end
      cyc();
      mem_rvalid_i = 0;
      cyc();
   endtask

   task automatic test_starvation();
      int o = 0;
      instr_req_i = 1; instr_addr_i = 32'h500; data_req_i = 1; data_addr_i = 32'h600; data_we_i = 0; mem_gnt_i = 1;
      for (int i = 0; i < 10; i++) begin
         mem_rvalid_i = o > 0; #4;
         tests++; if ({instr_gnt_o, data_gnt_o} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
            fails++; $display("FAIL starve.grant[%0d] got=%b%b", i, instr_gnt_o, data_gnt_o); end
         cyc();
         o = o + 1 - int'(mem_rvalid_i);
         if (i % 5 == 4) instr_addr_i = instr_addr_i + 4;
      end
      instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
      while (o > 0) begin mem_rvalid_i = 1; cyc(); o--; end
      mem_rvalid_i = 0;
      cyc();
   endtask

   task automatic test_full();
      data_req_i = 1; data_addr_i = 32'h700; mem_gnt_i = 1;
      for (int i = 0; i < 2; i++) begin
         #4;
         tests++; if (data_gnt_o !== 1'b1) begin fails++; $display("FAIL full.fill[%0d] gnt got=%b exp=1", i, data_gnt_o); end
         cyc();
      end
      data_addr_i = 32'h704; #4;
      tests++; if ({mem_req_o, data_gnt_o, busy_o} !== 3'b001) begin fails++; $display("FAIL full.stall got=%b exp=001", {mem_req_o, data_gnt_o, busy_o}); end
      cyc();
      mem_rvalid_i = 1; #4;
      tests++; if ({mem_req_o, data_gnt_o, data_rvalid_o} !== 3'b111) begin fails++; $display("FAIL full.pop_push got=%b exp=111", {mem_req_o, data_gnt_o, data_rvalid_o}); end
      cyc();
      mem_rvalid_i = 0; data_addr_i = 32'h708; #4;
      tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL full.still_full req got=%b exp=0", mem_req_o); end
      cyc();
      data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      cyc(); cyc();
      mem_rvalid_i = 0; #4;
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL full.drained busy got=%b exp=0", busy_o); end
      cyc();
   endtask

   task automatic test_reset_mid();
      data_req_i = 1; data_addr_i = 32'h800; mem_gnt_i = 1;
      cyc(); cyc();
      data_req_i = 0; mem_gnt_i = 0; rst_ni = 0; mem_rvalid_i = 1; #4;
      tests++; if (all_outs() !== '0) begin fails++; $display("FAIL rst_mid.outs got=%h exp=0", all_outs()); end
      cyc();
      mem_rvalid_i = 0; rst_ni = 1; #4;
      tests++; if ({busy_o, instr_rvalid_o, data_rvalid_o} !== 3'b000) begin fails++; $display("FAIL rst_mid.empty got=%b exp=000", {busy_o, instr_rvalid_o, data_rvalid_o}); end
      cyc();
   endtask

   task automatic test_random();
      int q[$];
      int lock = -1, starve = 0, w;
      logic full, ereq, egi, egd, eri, erd;
      logic [31:0] eaddr;
      for (int c = 0; c < 2100; c++) begin
         if (c < 2000) begin
            if (!instr_req_i && $urandom_range(1, 0) == 1) begin instr_req_i = 1; instr_addr_i = $urandom; end
            if (!data_req_i && $urandom_range(1, 0) == 1) begin
               data_req_i = 1; data_we_i = 1'($urandom); data_be_i = 4'($urandom); data_addr_i = $urandom; data_wdata_i = $urandom;
            end
            mem_gnt_i = $urandom_range(3, 0) != 0;
            mem_rvalid_i = q.size() > 0 && $urandom_range(1, 0) == 1;
         end else begin
            mem_gnt_i = 1; mem_rvalid_i = q.size() > 0;
         end
         mem_rdata_i = $urandom; mem_err_i = 1'($urandom);
         full = q.size() == MaxOut && !mem_rvalid_i;
         w = lock >= 0 ? lock : (instr_req_i && (starve == Starve || !data_req_i)) ? 0 : data_req_i ? 1 : -1;
         ereq = w >= 0 && !full;
         egi = ereq && mem_gnt_i && w == 0;
         egd = ereq && mem_gnt_i && w == 1;
         eri = mem_rvalid_i && q[0] == 0;
         erd = mem_rvalid_i && q[0] == 1;
         eaddr = !ereq ? 32'h0 : w == 0 ? instr_addr_i : data_addr_i;
         #4;
         tests++; if ({mem_req_o, instr_gnt_o, data_gnt_o} !== {ereq, egi, egd}) begin
            fails++; $display("FAIL rand.arb[%0d] got=%b exp=%b", c, {mem_req_o, instr_gnt_o, data_gnt_o}, {ereq, egi, egd}); end
         tests++; if (mem_addr_o !== eaddr || mem_we_o !== (ereq && w == 1 && data_we_i)) begin
            fails++; $display("FAIL rand.payload[%0d] got=%h/%b exp=%h", c, mem_addr_o, mem_we_o, eaddr); end
         tests++; if ({instr_rvalid_o, data_rvalid_o, data_rdata_o, instr_err_o} !== {eri, erd, mem_rdata_i, mem_err_i}) begin
            fails++; $display("FAIL rand.resp[%0d] got=%b%b exp=%b%b", c, instr_rvalid_o, data_rvalid_o, eri, erd); end
         tests++; if (busy_o !== (instr_req_i || data_req_i || q.size() != 0)) begin
            fails++; $display("FAIL rand.busy[%0d] got=%b", c, busy_o); end
         if (mem_rvalid_i) void'(q.pop_front());
         if (ereq && mem_gnt_i) q.push_back(w);
         lock = (ereq && !mem_gnt_i) ? w : -1;
         starve = (!instr_req_i || egi) ? 0 : (egd && starve < Starve) ? starve + 1 : starve;
         cyc();
         if (egi) instr_req_i = 0;
         if (egd) data_req_i = 0;
      end
      mem_gnt_i = 0; mem_rvalid_i = 0;
      tests++; if (q.size() != 0 || instr_req_i || data_req_i) begin
         fails++; $display("FAIL rand.drain outstanding got=%0d exp=0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_instr_only();
      test_both();
      test_lock();
      test_starvation();
      test_full();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vcve2_mem_arbiter.md
Name: vcve2_mem_arbiter

Overview:
- Arbitrates the core's instruction-fetch and data (LSU) request/grant/rvalid ports onto one shared single-port memory bus.
- Lets the core run against one unified memory.
- Sits between vcve2_top's instr_*/data_* ports and the memory, or a bus bridge.
- Tracks outstanding transactions in order, so each response is routed back to the requester that issued it.

Parameters:
- MaxOutstanding, 2, max granted-but-unanswered transactions on the shared bus (1..4).
- StarveLimit, 4, consecutive data grants allowed while an instruction request waits; after that, instr wins the next arbitration.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch response data
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  LSU request
- data_we_i  in  1  LSU write enable
- data_be_i  in  4  LSU byte enables
- data_addr_i  in  32  LSU address
- data_wdata_i  in  32  LSU write data
- data_gnt_o  out  1  LSU grant
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU bus error
- mem_req_o  out  1  shared bus request
- mem_we_o  out  1  shared write enable
- mem_be_o  out  4  shared byte enables
- mem_addr_o  out  32  shared address
- mem_wdata_o  out  32  shared write data
- mem_gnt_i  in  1  shared grant
- mem_rvalid_i  in  1  shared response valid
- mem_rdata_i  in  32  shared read data
- mem_err_i  in  1  shared error
- busy_o  out  1  any request pending or response outstanding

Behaviour:
- Reset (async, rst_ni low):
  - outputs: all 0.
  - internal state: outstanding FIFO empty (count=0), owner register = NONE, starvation counter = 0.
  - A reset mid-transaction discards all outstanding entries; late mem_rvalid_i after reset is dropped.
- Handshake rules:
  - Requesters hold req and payload stable until gnt.
  - The arbiter guarantees the same on the mem side.
- Owner FSM, states IDLE, LOCK_I, LOCK_D:
  - IDLE:
    - If count==MaxOutstanding and no pop this cycle: mem_req_o=0.
    - Otherwise select a winner. Data has priority, except that instr wins when starve_cnt==StarveLimit and instr_req_i=1.
    - Winner payload is driven combinationally and mem_req_o=1 in the same cycle (zero added latency).
    - If mem_gnt_i=0: move to LOCK_<winner>.
  - LOCK_x: keep selecting x regardless of the other requester until mem_gnt_i=1, then return to IDLE. Guarantees req/payload stability.
- Instruction payload on the mem bus: we=0, be=4'hF, wdata=0.
- Grant: mem_gnt_i is forwarded to the selected requester only; the other gnt_o is 0.
- Starvation counter:
  - Increments on a data grant while instr_req_i=1, saturating at StarveLimit.
  - Clears on any instr grant.
  - Clears when instr_req_i=0.
- Full check: mem_req_o is raised only if count<MaxOutstanding, or if mem_rvalid_i=1 in the same cycle (pop frees a slot).
  - Once raised, req is never dropped before gnt, because count only grows on a grant.
- Outstanding FIFO:
  - Depth MaxOutstanding, 1-bit source id (0=instr, 1=data), in order.
  - Push on mem_req_o & mem_gnt_i. Pop on mem_rvalid_i.
  - Simultaneous push and pop: count unchanged. Correct even when full, and when empty with a 0-cycle response is not allowed (rvalid is at least 1 cycle after gnt).
- Response routing:
  - <head>_rvalid_o = mem_rvalid_i & (head==<head>).
  - rdata/err are broadcast to both requesters; only the rvalid is qualified.
  - Same-cycle pass-through, no response latency.
- mem_rvalid_i with an empty FIFO is a protocol error:
  - Ignored.
  - An assertion fires in simulation.
- busy_o = instr_req_i | data_req_i | (count!=0). Intended to feed core_busy for the top-level clock gate.
- Assertions:
  - Known-value checks on all outputs.
  - Request payload stable while mem_req_o & !mem_gnt_i.
  - Never both gnt_o high together.
  - count ≤ MaxOutstanding.

Decomposition:
- vcve2_pkg additions:
  - typedef enum arb_src_e {ArbSrcInstr=1'b0, ArbSrcData=1'b1}.
  - typedef enum arb_state_e {ArbIdle, ArbLockI, ArbLockD}.
- Sub-module vcve2_arb_id_fifo: a parameterised in-order id FIFO exposing push, pop, head, count, full and empty. Reusable for future bus bridges.
- Arbitration FSM and starvation counter live in the top module.

Test Plan:
- Only instr_req_i=1 at addr 0x80, gnt next cycle, rvalid with 0xDEADBEEF 2 cycles later -> mem_addr_o=0x80, we=0, be=F; instr_rvalid_o=1, rdata 0xDEADBEEF; data_rvalid_o=0.
- Both requests in the same cycle, data write 0x100 be=4'h3 -> data granted first; instr granted the cycle after; responses route D then I in issue order.
- Data req raised, mem_gnt_i held 0 for 3 cycles while instr_req_i rises -> mem payload stays at the data transaction; no switch to instr until grant.
- Data req continuously high, instr waiting, every req granted -> after 4 data grants the 5th grant goes to instr; counter clears.
- Full stall: 2 granted, no rvalid -> mem_req_o=0. rvalid arrives the same cycle as a new request -> req issued and granted; count stays 2.
- Reset asserted with 2 outstanding, then stray mem_rvalid_i -> all outputs 0; no rvalid_o produced; count=0.
